regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the MIPS datapath; successor to the single-write, two-read register file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports, with write-to-read bypass.
- Register 0 is optionally hardwired to zero.
- A clear state machine zeroes the array one entry per cycle after reset or on request, so no wide one-cycle reset fan-out is needed.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (range 1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0 and writes to it are discarded.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  one-cycle pulse that requests a full array clear.
- ready  output  1  1 = array valid and writes accepted.
- wr0_en  input  1  write port 0 enable.
- wr0_addr  input  ADDR_W  write port 0 address.
- wr0_data  input  DATA_W  write port 0 data.
- wr1_en  input  1  write port 1 enable.
- wr1_addr  input  ADDR_W  write port 1 address.
- wr1_data  input  DATA_W  write port 1 data.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-high, sampled on the rising edge of clock.
- FSM states: CLEAR and RUN.
- reset forces state CLEAR with clr_cnt=0 and ready=0. This applies at any time, including mid-clear, where the counter restarts at 0.
- CLEAR: each cycle writes 0 to entry clr_cnt, then clr_cnt increments. The cycle that writes entry DEPTH-1 moves to RUN, so ready=1 exactly DEPTH cycles after reset deasserts.
- In CLEAR, wr0/wr1 are ignored, all rd_data read 0, and clear is ignored.
- RUN: ready=1. A clear pulse moves to CLEAR on the next edge with clr_cnt=0; any write sampled in the same cycle as that clear pulse is dropped.
- Writes are committed on the rising edge of clock when wrX_en=1 and ready=1.
- If both write ports target the same address in one cycle, port 1 wins.
- If ZERO_REG=1, writes to address 0 are discarded.
- Reads are combinational with zero-cycle latency.
- Bypass priority per read port:
  1. Address 0 with ZERO_REG=1 -> 0.
  2. Otherwise, wr1_en and ready and addr match -> wr1_data.
  3. Otherwise, wr0_en and ready and addr match -> wr0_data.
  4. Otherwise -> stored array value.
- Read ports are independent; any number of ports may read the same address.
- Widths: no arithmetic on data. clr_cnt is ADDR_W+1 bits wide to detect the final entry without wrap.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: adds ports alloc_en (input, 1), alloc_addr (input, ADDR_W) and busy (output, NUM_RD).
  - Maintains one pending bit per entry.
  - alloc_en with ready=1 sets the pending bit of alloc_addr on the edge.
  - A committed write from either port clears the pending bit of its address.
  - Alloc and write to the same address in the same cycle: pending ends set (new producer wins).
  - busy[k] = pending[rd_addr port k], combinational.
  - Entry 0 is never pending when ZERO_REG=1.
  - All pending bits are cleared on entering CLEAR; busy=0 while ready=0.
- Undefined: these ports and the pending storage do not exist; the rest of the behaviour is unchanged.

Test Plan:
- Reset and clear timing: reset high 2 cycles, then low -> ready=0 for exactly 32 cycles, ready=1 on cycle 32; every read of addresses 0..31 returns 0.
- Write then read, plus zero register: wr0 addr 5 data 0xDEADBEEF, next cycle read port 0 addr 5 -> 0xDEADBEEF. wr1 addr 0 data 0x1234 -> addr 0 reads 0.
- Bypass and port conflict: same cycle wr0 addr 7 data 0x11 and wr1 addr 7 data 0x22, reading addr 7 on all ports -> 0x22 combinationally that cycle and 0x22 from storage afterwards.
- Write blocked during clear: fill addr 3 with 0xA5A5A5A5, pulse clear, drive wr0 addr 3 data 0x5 during CLEAR -> ready low 32 cycles; addr 3 reads 0 afterwards.
- Reset mid-clear: assert reset at clr_cnt=10 -> count restarts; ready rises 32 cycles after reset deasserts.
- Scoreboard (REGFILE_SCOREBOARD_EN defined): alloc addr 9 -> busy on a port reading addr 9 = 1. Write addr 9 with alloc addr 9 in the same cycle -> busy stays 1. Write addr 9 alone -> busy 0 next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports with bypass,
// and a one-entry-per-cycle clear sequencer. Define REGFILE_SCOREBOARD_EN for pending-bit tracking.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  output logic                       ready,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic [NUM_RD-1:0]          busy
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr0_commit, wr1_commit;

  assign ready = (state_q == ST_RUN);

  // A write sampled alongside a clear pulse is dropped; entry 0 is read-only when hardwired.
  assign wr0_commit = wr0_en && ready && !clear && !(ZR && (wr0_addr == '0));
  assign wr1_commit = wr1_en && ready && !clear && !(ZR && (wr1_addr == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CNT_W'(1);
        if (clr_cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Array storage: no reset; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end else begin
        if (wr0_commit) mem_q[wr0_addr] <= wr0_data;
        if (wr1_commit) mem_q[wr1_addr] <= wr1_data;
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (!ready || clear) begin
      pending_d = '0;
    end else begin
      if (wr0_commit) pending_d[wr0_addr] = 1'b0;
      if (wr1_commit) pending_d[wr1_addr] = 1'b0;
      // A new allocation overrides a completing write to the same entry.
      if (alloc_en && !(ZR && (alloc_addr == '0))) pending_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Later assignments take priority: wr1 over wr0, zero/not-ready over everything.
    always_comb begin
      rdat = mem_q[ra];
      if (wr0_en && (wr0_addr == ra)) rdat = wr0_data;
      if (wr1_en && (wr1_addr == ra)) rdat = wr1_data;
      if (!ready || (ZR && (ra == '0))) rdat = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;

`ifdef REGFILE_SCOREBOARD_EN
    assign busy[k] = ready && pending_q[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model;
// scoreboard checks are compiled when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int RAW   = NR * AW;

  logic            clock;
  logic            reset;
  logic            clear;
  logic            ready;
  logic            wr0_en;
  logic [AW-1:0]   wr0_addr;
  logic [DW-1:0]   wr0_data;
  logic            wr1_en;
  logic [AW-1:0]   wr1_addr;
  logic [DW-1:0]   wr1_data;
  logic [RAW-1:0]  rd_addr;
  logic [NR*DW-1:0] rd_data;
`ifdef REGFILE_SCOREBOARD_EN
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic [NR-1:0]   busy;
`endif

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .ready    (ready),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy       (busy)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: array contents, cycles left until the array is usable, pending bits.
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = DEPTH;
  bit            ref_pend [DEPTH];

  task automatic wipe_model();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_pend[i] = 1'b0;
    end
    clear_left = DEPTH;
  endtask

  task automatic model_edge();
    if (reset) begin
      wipe_model();
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (clear) begin
      wipe_model();
    end else begin
      if (wr0_en && wr0_addr != 0) begin ref_mem[wr0_addr] = wr0_data; ref_pend[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin ref_mem[wr1_addr] = wr1_data; ref_pend[wr1_addr] = 1'b0; end
`ifdef REGFILE_SCOREBOARD_EN
      if (alloc_en && alloc_addr != 0) ref_pend[alloc_addr] = 1'b1;
`endif
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (clear_left > 0 || a == 0) return '0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return ref_mem[a];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [AW-1:0] port_addr(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  task automatic set_all_ports(input logic [AW-1:0] a);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    logic [DW-1:0] got;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      rd_addr = RAW'($urandom);
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ready_low cycle %0d: got %b want 0", c, ready);
      end
      got = rd_data[0 +: DW];
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL reset_read_zero cycle %0d: got %h want 0", c, got);
      end
      tick();
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_high: got %b want 1", ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_all_ports(AW'(a));
      #1;
      for (int k = 0; k < NR; k++) begin
        got = rd_data[k*DW +: DW];
        n_cmp++;
        if (got !== '0) begin
          n_bad++;
          $display("FAIL reset_sweep addr %0d port %0d: got %h want 0", a, k, got);
        end
      end
    end
  endtask

  task automatic test_write_zero();
    logic [DW-1:0] got;
    wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    tick();
    wr0_en = 1'b0;
    rd_addr[0 +: AW] = 5;
    #1;
    got = rd_data[0 +: DW];
    n_cmp++;
    if (got !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL write_read_addr5: got %h want deadbeef", got);
    end
    wr1_en = 1'b1; wr1_addr = 0; wr1_data = 32'h1234;
    rd_addr[0 +: AW] = 0;
    #1;
    got = rd_data[0 +: DW];
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL zero_reg_bypass: got %h want 0", got);
    end
    tick();
    wr1_en = 1'b0;
    #1;
    got = rd_data[0 +: DW];
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL zero_reg_stored: got %h want 0", got);
    end
  endtask

  task automatic test_bypass_conflict();
    logic [DW-1:0] got;
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'h22;
    set_all_ports(7);
    #1;
    for (int k = 0; k < NR; k++) begin
      got = rd_data[k*DW +: DW];
      n_cmp++;
      if (got !== 32'h22) begin
        n_bad++;
        $display("FAIL conflict_bypass port %0d: got %h want 22", k, got);
      end
    end
    tick();
    wr0_en = 1'b0; wr1_en = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) begin
      got = rd_data[k*DW +: DW];
      n_cmp++;
      if (got !== 32'h22) begin
        n_bad++;
        $display("FAIL conflict_stored port %0d: got %h want 22", k, got);
      end
    end
  endtask

  task automatic test_clear_blocks_write();
    logic [DW-1:0] got;
    wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'hA5A5A5A5;
    tick();
    wr0_en = 1'b0;
    rd_addr[0 +: AW] = 3;
    #1;
    got = rd_data[0 +: DW];
    n_cmp++;
    if (got !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL clear_prefill: got %h want a5a5a5a5", got);
    end
    clear = 1'b1;
    wr1_en = 1'b1; wr1_addr = 3; wr1_data = 32'h77;
    tick();
    clear = 1'b0; wr1_en = 1'b0;
    wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'h5;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_ready_low cycle %0d: got %b want 0", c, ready);
      end
      got = rd_data[0 +: DW];
      n_cmp++;
      if (got !== '0) begin
        n_bad++;
        $display("FAIL clear_read_zero cycle %0d: got %h want 0", c, got);
      end
      tick();
    end
    wr0_en = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_ready_high: got %b want 1", ready);
    end
    got = rd_data[0 +: DW];
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL clear_addr3_zero: got %h want 0", got);
    end
  endtask

  task automatic test_reset_mid_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL midclear_ready_low cycle %0d: got %b want 0", c, ready);
      end
      tick();
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midclear_ready_high: got %b want 1", ready);
    end
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard();
    rd_addr[0 +: AW] = 9;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_idle: got %b want 0", busy[0]);
    end
    alloc_en = 1'b1; alloc_addr = 9;
    tick();
    alloc_en = 1'b0;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_alloc: got %b want 1", busy[0]);
    end
    alloc_en = 1'b1; wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h99;
    tick();
    alloc_en = 1'b0; wr0_en = 1'b0;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_alloc_and_write: got %b want 1", busy[0]);
    end
    wr0_en = 1'b1;
    tick();
    wr0_en = 1'b0;
    #1;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_write_release: got %b want 0", busy[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    for (int c = 0; c < 400; c++) begin
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = AW'($urandom_range(0, 15));
      wr0_data = DW'($urandom);
      wr1_en   = ($urandom_range(0, 1) == 1);
      wr1_addr = AW'($urandom_range(0, 15));
      wr1_data = DW'($urandom);
      rd_addr  = RAW'($urandom);
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
      clear    = ($urandom_range(0, 149) == 0);
`ifdef REGFILE_SCOREBOARD_EN
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, 15));
`endif
      #1;
      n_cmp++;
      if (ready !== (clear_left == 0)) begin
        n_bad++;
        $display("FAIL rand_ready cycle %0d: got %b want %b", c, ready, clear_left == 0);
      end
      for (int k = 0; k < NR; k++) begin
        got  = rd_data[k*DW +: DW];
        want = exp_rd(port_addr(k));
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL rand_read cycle %0d port %0d addr %0d: got %h want %h",
                   c, k, port_addr(k), got, want);
        end
`ifdef REGFILE_SCOREBOARD_EN
        n_cmp++;
        if (busy[k] !== (clear_left == 0 && ref_pend[port_addr(k)])) begin
          n_bad++;
          $display("FAIL rand_busy cycle %0d port %0d: got %b want %b",
                   c, k, busy[k], clear_left == 0 && ref_pend[port_addr(k)]);
        end
`endif
      end
      tick();
    end
    clear = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    alloc_en = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    rd_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
    alloc_en = 1'b0; alloc_addr = '0;
`endif
    wipe_model();
    #2;
    test_reset();
    test_write_zero();
    test_bypass_conflict();
    test_clear_blocks_write();
    test_reset_mid_clear();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
